// File: rtl/mem_responder.sv
// Shared word-array responder for the core's imem (read-only) and dmem (load/store) req/ack
// channels. Each channel runs its own IDLE->BUSY->ACK FSM with a fixed programmable latency.

package simple_processor_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
endpackage

module mem_responder #(
  parameter int ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  prog_we_i,
  input  logic [ADDR_WIDTH-1:0] prog_addr_i,
  input  logic [DATA_WIDTH-1:0] prog_wdata_i,
  input  logic                  imem_req_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  output logic                  imem_ack_o,
  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_ack_o,
  output logic [1:0]            imem_state_o,
  output logic [1:0]            dmem_state_o
);

  // Handshake: a request is taken only when the channel is IDLE and req is high at a clock
  // edge; ack is a single-cycle pulse LATENCY cycles later, rdata valid while ack is high.

  localparam int IW = ADDR_WIDTH - 1;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [IW:0] DEPTH_W = (IW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- imem channel ----------------
  state_t                i_state;
  logic [CW-1:0]         i_cnt;
  logic [ADDR_WIDTH-1:0] i_addr_q;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [IW-1:0]         i_idx;
  logic                  i_hit;
  logic                  i_go_ack;
  logic [DATA_WIDTH-1:0] i_rd;

  // With LATENCY==1 the ACK edge is the accept edge, so live inputs are used there.
  assign i_addr   = (i_state == ST_IDLE) ? imem_addr_i : i_addr_q;
  assign i_idx    = i_addr[ADDR_WIDTH-1:1];
  assign i_hit    = ({1'b0, i_idx} < DEPTH_W);
  assign i_go_ack = ((i_state == ST_IDLE) && imem_req_i && (LATENCY == 1)) ||
                    ((i_state == ST_BUSY) && (i_cnt == CW'(1)));
  assign i_rd     = i_hit ? mem[i_idx[MW-1:0]] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_state      <= ST_IDLE;
      i_cnt        <= '0;
      i_addr_q     <= '0;
      imem_ack_o   <= 1'b0;
      imem_rdata_o <= '0;
    end else begin
      imem_ack_o <= 1'b0;
      case (i_state)
        ST_IDLE: if (imem_req_i) begin
          i_addr_q <= imem_addr_i;
          i_cnt    <= CW'(LATENCY - 1);
          i_state  <= (LATENCY == 1) ? ST_ACK : ST_BUSY;
        end
        ST_BUSY: begin
          i_cnt <= i_cnt - CW'(1);
          if (i_cnt == CW'(1)) i_state <= ST_ACK;
        end
        ST_ACK:  i_state <= ST_IDLE;
        default: i_state <= ST_IDLE;
      endcase
      if (i_go_ack) begin
        imem_ack_o   <= 1'b1;
        imem_rdata_o <= i_rd;
      end
    end
  end

  // ---------------- dmem channel ----------------
  state_t                d_state;
  logic [CW-1:0]         d_cnt;
  logic [ADDR_WIDTH-1:0] d_addr_q;
  logic                  d_we_q;
  logic [DATA_WIDTH-1:0] d_wdata_q;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_we;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [IW-1:0]         d_idx;
  logic                  d_hit;
  logic                  d_go_ack;
  logic [DATA_WIDTH-1:0] d_rd;

  assign d_addr   = (d_state == ST_IDLE) ? dmem_addr_i  : d_addr_q;
  assign d_we     = (d_state == ST_IDLE) ? dmem_we_i    : d_we_q;
  assign d_wdata  = (d_state == ST_IDLE) ? dmem_wdata_i : d_wdata_q;
  assign d_idx    = d_addr[ADDR_WIDTH-1:1];
  assign d_hit    = ({1'b0, d_idx} < DEPTH_W);
  assign d_go_ack = ((d_state == ST_IDLE) && dmem_req_i && (LATENCY == 1)) ||
                    ((d_state == ST_BUSY) && (d_cnt == CW'(1)));
  assign d_rd     = d_hit ? mem[d_idx[MW-1:0]] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_state      <= ST_IDLE;
      d_cnt        <= '0;
      d_addr_q     <= '0;
      d_we_q       <= 1'b0;
      d_wdata_q    <= '0;
      dmem_ack_o   <= 1'b0;
      dmem_rdata_o <= '0;
    end else begin
      dmem_ack_o <= 1'b0;
      case (d_state)
        ST_IDLE: if (dmem_req_i) begin
          d_addr_q  <= dmem_addr_i;
          d_we_q    <= dmem_we_i;
          d_wdata_q <= dmem_wdata_i;
          d_cnt     <= CW'(LATENCY - 1);
          d_state   <= (LATENCY == 1) ? ST_ACK : ST_BUSY;
        end
        ST_BUSY: begin
          d_cnt <= d_cnt - CW'(1);
          if (d_cnt == CW'(1)) d_state <= ST_ACK;
        end
        ST_ACK:  d_state <= ST_IDLE;
        default: d_state <= ST_IDLE;
      endcase
      if (d_go_ack) begin
        dmem_ack_o   <= 1'b1;
        dmem_rdata_o <= d_we ? '0 : d_rd;
      end
    end
  end

  // ---------------- shared array ----------------
  logic [IW-1:0] p_idx;
  logic          p_hit;

  assign p_idx = prog_addr_i[ADDR_WIDTH-1:1];
  assign p_hit = ({1'b0, p_idx} < DEPTH_W);

  // Preload is written last so it wins over a store to the same word on the same edge;
  // the imem read above sees pre-edge contents (read-before-write).
  always_ff @(posedge clk_i) begin
    if (!rst_i && d_go_ack && d_we && d_hit) mem[d_idx[MW-1:0]] <= d_wdata;
    if (prog_we_i && p_hit) mem[p_idx[MW-1:0]] <= prog_wdata_i;
  end

  assign imem_state_o = i_state;
  assign dmem_state_o = d_state;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{prog_addr_i[0], imem_addr_i[0], dmem_addr_i[0],
                             i_addr_q[0], d_addr_q[0]};

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, fetch/load/store latency, read-before-write,
// out-of-range access, preload priority, reset abort and back-to-back fetch throughput.

module tb_mem_responder;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int DEP = 256;
  localparam int L   = 2;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic          prog_we_i    = 1'b0;
  logic [AW-1:0] prog_addr_i  = '0;
  logic [DW-1:0] prog_wdata_i = '0;
  logic          imem_req_i   = 1'b0;
  logic [AW-1:0] imem_addr_i  = '0;
  logic [DW-1:0] imem_rdata_o;
  logic          imem_ack_o;
  logic          dmem_req_i   = 1'b0;
  logic          dmem_we_i    = 1'b0;
  logic [AW-1:0] dmem_addr_i  = '0;
  logic [DW-1:0] dmem_wdata_i = '0;
  logic [DW-1:0] dmem_rdata_o;
  logic          dmem_ack_o;
  logic [1:0]    imem_state_o;
  logic [1:0]    dmem_state_o;

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .LATENCY(L)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_wdata_i(prog_wdata_i),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
    .imem_rdata_o(imem_rdata_o), .imem_ack_o(imem_ack_o),
    .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_rdata_o(dmem_rdata_o), .dmem_ack_o(dmem_ack_o),
    .imem_state_o(imem_state_o), .dmem_state_o(dmem_state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- driver / check tasks ----------------
  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_we_i = 1'b1; prog_addr_i = a; prog_wdata_i = d;
    tick();
    prog_we_i = 1'b0;
  endtask

  // Issue one fetch; returns the data seen with ack and the ack cycle (accept cycle = 0).
  task automatic imem_rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    imem_req_i = 1'b1; imem_addr_i = a;
    tick();
    imem_req_i = 1'b0;
    lat = 1;
    while (!imem_ack_o && lat < 10) begin
      tick();
      lat++;
    end
    d = imem_rdata_o;
    if (!imem_ack_o) lat = -1;
    tick();
    chk("imem_ack_pulse", {31'd0, imem_ack_o}, 32'd0);
  endtask

  task automatic dmem_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         output logic [DW-1:0] d, output int lat);
    dmem_req_i = 1'b1; dmem_we_i = we; dmem_addr_i = a; dmem_wdata_i = wd;
    tick();
    dmem_req_i = 1'b0;
    lat = 1;
    while (!dmem_ack_o && lat < 10) begin
      tick();
      lat++;
    end
    d = dmem_rdata_o;
    if (!dmem_ack_o) lat = -1;
    tick();
    chk("dmem_ack_pulse", {31'd0, dmem_ack_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] d;
    int lat;

    // 1: reset held two cycles with a fetch request pending
    rst_i = 1'b1; imem_req_i = 1'b1; imem_addr_i = 16'h0010;
    prog_we_i = 1'b1; prog_addr_i = 16'h0010; prog_wdata_i = 16'h1234;
    tick();
    chk("rst_imem_ack_c1", {31'd0, imem_ack_o}, 32'd0);
    chk("rst_dmem_ack_c1", {31'd0, dmem_ack_o}, 32'd0);
    tick();
    prog_we_i = 1'b0;
    chk("rst_imem_ack_c2", {31'd0, imem_ack_o}, 32'd0);
    chk("rst_imem_rdata", {16'd0, imem_rdata_o}, 32'd0);
    chk("rst_dmem_rdata", {16'd0, dmem_rdata_o}, 32'd0);
    chk("rst_imem_state", {30'd0, imem_state_o}, 32'd0);
    rst_i = 1'b0;
    tick();                                   // accept edge, cycle 1 after accept
    chk("post_rst_busy_state", {30'd0, imem_state_o}, 32'd1);
    chk("post_rst_ack_c1", {31'd0, imem_ack_o}, 32'd0);
    imem_req_i = 1'b0;
    tick();                                   // cycle 2 = LATENCY
    chk("post_rst_ack_c2", {31'd0, imem_ack_o}, 32'd1);
    chk("post_rst_rdata", {16'd0, imem_rdata_o}, 32'h1234);
    tick();
    chk("post_rst_ack_c3", {31'd0, imem_ack_o}, 32'd0);

    // 2: fetch from preloaded word, then odd byte address of the same word
    imem_rd(16'h0010, d, lat);
    chk("fetch_10_lat", lat, L);
    chk("fetch_10_data", {16'd0, d}, 32'h1234);
    imem_rd(16'h0011, d, lat);
    chk("fetch_11_data", {16'd0, d}, 32'h1234);

    // 3: store then load
    dmem_op(1'b1, 16'h0020, 16'hBEEF, d, lat);
    chk("store_20_lat", lat, L);
    chk("store_20_rdata", {16'd0, d}, 32'h0);
    dmem_op(1'b0, 16'h0020, 16'h0000, d, lat);
    chk("load_20_lat", lat, L);
    chk("load_20_data", {16'd0, d}, 32'hBEEF);

    // 4: same-edge imem read and dmem store to the same word
    preload(16'h0020, 16'hAAAA);
    imem_req_i = 1'b1; imem_addr_i = 16'h0020;
    dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 16'h0020; dmem_wdata_i = 16'h5555;
    tick();
    imem_req_i = 1'b0; dmem_req_i = 1'b0;
    tick();
    chk("rbw_imem_ack", {31'd0, imem_ack_o}, 32'd1);
    chk("rbw_dmem_ack", {31'd0, dmem_ack_o}, 32'd1);
    chk("rbw_imem_old", {16'd0, imem_rdata_o}, 32'hAAAA);
    chk("rbw_dmem_rdata", {16'd0, dmem_rdata_o}, 32'h0);
    tick();
    imem_rd(16'h0020, d, lat);
    chk("rbw_imem_new", {16'd0, d}, 32'h5555);

    // 5: out-of-range accesses (index == DEPTH)
    preload(16'h0000, 16'h0F0F);
    dmem_op(1'b0, 16'h0020, 16'h0000, d, lat);
    chk("load_20_again", {16'd0, d}, 32'h5555);
    dmem_op(1'b0, 16'(2 * DEP), 16'h0000, d, lat);
    chk("oor_load_lat", lat, L);
    chk("oor_load_data", {16'd0, d}, 32'h0);
    dmem_op(1'b1, 16'(2 * DEP), 16'h1111, d, lat);
    chk("oor_store_lat", lat, L);
    imem_rd(16'h0000, d, lat);
    chk("oor_word0_kept", {16'd0, d}, 32'h0F0F);
    imem_rd(16'(2 * DEP + 1), d, lat);
    chk("oor_fetch_data", {16'd0, d}, 32'h0);

    // preload wins over a store committing to the same word on the same edge
    dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 16'h0024; dmem_wdata_i = 16'h3333;
    tick();                                   // store accepted
    dmem_req_i = 1'b0;
    prog_we_i = 1'b1; prog_addr_i = 16'h0024; prog_wdata_i = 16'h7777;
    tick();                                   // store commit edge
    prog_we_i = 1'b0;
    chk("prio_store_ack", {31'd0, dmem_ack_o}, 32'd1);
    tick();
    imem_rd(16'h0024, d, lat);
    chk("prio_prog_wins", {16'd0, d}, 32'h7777);

    // 6a: reset while a store is in flight
    preload(16'h0030, 16'h4242);
    dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 16'h0030; dmem_wdata_i = 16'h9999;
    tick();
    dmem_req_i = 1'b0;
    chk("abort_busy", {30'd0, dmem_state_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    chk("abort_ack_c1", {31'd0, dmem_ack_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    chk("abort_ack_c2", {31'd0, dmem_ack_o}, 32'd0);
    chk("abort_idle", {30'd0, dmem_state_o}, 32'd0);
    imem_rd(16'h0030, d, lat);
    chk("abort_word_kept", {16'd0, d}, 32'h4242);

    // 6b: fetch request held high; address changes during BUSY are ignored
    preload(16'h0040, 16'hA001);
    preload(16'h0042, 16'hA002);
    imem_req_i = 1'b1; imem_addr_i = 16'h0040;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("stream_ack_k%0d", k), {31'd0, imem_ack_o}, {31'd0, (k % 3) == 2});
      if (k == 1) imem_addr_i = 16'h0042;
      if (k == 2) chk("stream_data_1", {16'd0, imem_rdata_o}, 32'hA001);
      if (k == 4) imem_addr_i = 16'h0040;
      if (k == 5) begin
        chk("stream_data_2", {16'd0, imem_rdata_o}, 32'hA002);
        imem_req_i = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
